fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Parametrised successor to the F stage of the 5-stage pipeline. It owns the PC, issues pipelined instruction-memory reads, and buffers returned {instr, pc+4} pairs in a DEPTH-entry queue. This decouples fetch from decode stalls, and supports redirect (branch/jump) with discard of in-flight responses. It sits between instruction memory and the F→D boundary, and replaces the single F/D register with stall/flush.

Parameters:
W, 32, PC and instruction width
DEPTH, 4, queue entries (power of 2, ≥2); also the maximum of outstanding requests plus queued entries
RESET_PC, 0, PC value loaded on reset (low 2 bits must be 0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_adr  out  W  fetch address (= pcF)
imem_req  out  1  request valid this cycle
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid; responses return in request order
imem_rdata  in  W  instruction word
instr_valid  out  1  queue head valid
instrD  out  W  head instruction
pc4D  out  W  head PC+4
stallD  in  1  decode not consuming; head held
redirect  in  1  branch/jump taken
redirect_pc  in  W  target; bits [1:0] forced to 0
pclow  out  8  pcF[9:2]
err  out  1  sticky: rvalid with no outstanding request

Behaviour:
- Reset (reset=0, async): pcF=RESET_PC; queue empty; outstanding=0; drop=0; err=0; instr_valid=0; imem_req=0; instrD/pc4D=0.
- Request: imem_req = ~redirect & (count + outstanding < DEPTH). Accept = imem_req & imem_ready. On accept: pcF<=pcF+4, outstanding+1. This credit rule makes queue overflow impossible.
- Response: on imem_rvalid with outstanding>0: outstanding-1. If drop>0, the word is discarded and drop is decremented. Otherwise push {imem_rdata, addr+4}. PC+4 comes from a DEPTH-deep in-order address FIFO, or equivalently a response-PC counter.
- Latency: a request accepted at cycle t with rvalid at t+1 gives instr_valid at t+2. No bypass from memory to the head.
- Pop: instr_valid & ~stallD at an edge. Push and pop in the same cycle are allowed at any occupancy, and count is unchanged.
- Empty: instr_valid=0; instrD/pc4D hold their last values (don't-care for checking).
- Redirect (highest priority, same-cycle events): queue cleared (count=0); no request issued that cycle; pcF<=redirect_pc&~3; pop is ignored.
  - A response arriving in the redirect cycle is discarded.
  - drop <= outstanding minus (1 if rvalid that cycle).
  - The outstanding count continues to track the real bus.
  - The first request from the target is issued the cycle after redirect.
- Back-to-back redirects: the later one wins, and the drop calculation is reapplied.
- rvalid while outstanding=0: ignored, err<=1 until reset.
- PC wrap: pcF+4 wraps modulo 2^W silently.
- Reset mid-operation: all state is cleared immediately. Stale responses afterwards are treated as the rvalid-with-no-outstanding case above (err).

Decomposition:
- Shared package mips_pkg:
  - W default;
  - typedef fetch_entry_t {instr[W-1:0], pc4[W-1:0]};
  - constant INSTR_NOP = 0;
  - function clog2-based count width.
- One sub-module: fetchq_fifo. It is a synchronous DEPTH×entry FIFO with push, pop, clear, count, head. It uses an async active-low reset and gives clear priority over push/pop.
- Credit and drop logic stay in fetch_queue.

Test Plan:
- Reset, imem_ready=1, rvalid 1 cycle after each accept, stallD=0 → imem_adr 0,4,8,…; instr_valid from cycle 2; pc4D 4,8,12 in order; pclow 0,1,2.
- stallD=1 held for 10 cycles with DEPTH=4 → imem_req deasserts once count+outstanding=4; exactly 4 entries are held. Release stallD → the 4 entries pop in order with no loss or duplication.
- imem_ready toggling 1/0 every cycle → no duplicate or skipped addresses; pc4D strictly +4 per pop.
- Redirect to 0x100 while 2 requests are outstanding (responses at t+1, t+3) → both discarded; queue empty at t+1; next imem_adr=0x100; first instr_valid shows pc4D=0x104.
- Redirect in the same cycle as rvalid and pop, with redirect_pc=0x203 → response dropped; pcF=0x200; count=0; no request that cycle.
- rvalid pulsed with nothing outstanding → err=1 and stays set; queue unchanged. Assert reset mid-stream → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue: default widths, the queued entry
// layout and the occupancy-counter width helper.
package fetch_queue_pkg;

    localparam int unsigned W_DEF     = 32;
    localparam int unsigned DEPTH_DEF = 4;

    typedef struct packed {
        logic [W_DEF-1:0] instr;
        logic [W_DEF-1:0] pc4;
    } fetch_entry_t;

    localparam logic [W_DEF-1:0] INSTR_NOP = '0;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory and F->D boundary signals of the fetch queue.
// The master modport is the fetch queue itself.
interface fetch_queue_if #(
    parameter int unsigned W = fetch_queue_pkg::W_DEF
);
    logic [W-1:0] imem_adr;
    logic         imem_req;
    logic         imem_ready;
    logic         imem_rvalid;
    logic [W-1:0] imem_rdata;
    logic         instr_valid;
    logic [W-1:0] instrD;
    logic [W-1:0] pc4D;
    logic         stallD;
    logic         redirect;
    logic [W-1:0] redirect_pc;

    modport master (
        output imem_adr, imem_req, instr_valid, instrD, pc4D,
        input  imem_ready, imem_rvalid, imem_rdata, stallD, redirect, redirect_pc
    );

    modport slave (
        input  imem_adr, imem_req, instr_valid, instrD, pc4D,
        output imem_ready, imem_rvalid, imem_rdata, stallD, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous DEPTH-entry FIFO with push, pop and clear; clear overrides push/pop.
// The head is read straight from storage, so it holds stale data when empty.
module fetch_queue_fifo #(
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_clear,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_head,
    output logic [CW-1:0] o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem   <= '{default: '0};
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= r_wp + AW'(1);
            end
            if (i_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rp];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, issues credit-limited pipelined imem reads and queues
// {instr, pc+4} pairs for decode; redirects flush the queue and drop in-flight words.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned W        = W_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter logic [W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus,
    output logic [7:0]    o_pclow,
    output logic          o_err
);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned LW = CW + 1;

    logic [W-1:0]   r_pc;
    logic [W-1:0]   r_rsp_pc;
    logic [CW-1:0]  r_out;
    logic [CW-1:0]  r_drop;
    logic           r_err;

    logic [CW-1:0]  w_count;
    logic [2*W-1:0] w_head;
    logic [LW-1:0]  w_level;
    logic           w_req;
    logic           w_accept;
    logic           w_rv_ok;
    logic           w_push;
    logic           w_pop;

    // Credit rule: queued + in-flight never exceeds DEPTH, so the queue cannot overflow.
    always_comb begin
        w_level  = LW'(w_count) + LW'(r_out);
        w_req    = reset & ~bus.redirect & (w_level < LW'(DEPTH));
        w_accept = w_req & bus.imem_ready;
        w_rv_ok  = bus.imem_rvalid & (r_out != '0);
        w_push   = w_rv_ok & (r_drop == '0) & ~bus.redirect;
        w_pop    = (w_count != '0) & ~bus.stallD & ~bus.redirect;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
            r_out    <= '0;
            r_drop   <= '0;
            r_err    <= 1'b0;
        end else begin
            case ({w_accept, w_rv_ok})
                2'b10:   r_out <= r_out + CW'(1);
                2'b01:   r_out <= r_out - CW'(1);
                default: r_out <= r_out;
            endcase
            if (bus.imem_rvalid && (r_out == '0)) begin
                r_err <= 1'b1;
            end
            // Everything still in flight after this cycle belongs to the old path.
            if (bus.redirect) begin
                r_pc     <= bus.redirect_pc & ~W'(3);
                r_rsp_pc <= bus.redirect_pc & ~W'(3);
                r_drop   <= r_out - CW'(w_rv_ok);
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + W'(4);
                end
                if (w_rv_ok && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + W'(4);
                end
            end
        end
    end

    fetch_queue_fifo #(
        .DW    (2 * W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (bus.redirect),
        .i_data  ({bus.imem_rdata, r_rsp_pc + W'(4)}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.imem_adr    = r_pc;
    assign bus.imem_req    = w_req;
    assign bus.instr_valid = (w_count != '0);
    assign bus.instrD      = w_head[2*W-1:W];
    assign bus.pc4D        = w_head[W-1:0];
    assign o_pclow         = r_pc[9:2];
    assign o_err           = r_err;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: an in-order memory responder, a queue-based reference model
// of fetch/queue/redirect behaviour, directed scenarios and a randomized run.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [W-1:0] RESET_PC = '0;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pclow;
    logic       err;

    fetch_queue_if #(.W(W)) bus ();

    fetch_queue #(.W(W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .o_pclow (pclow),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] pc4;
        bit           stale;
    } out_t;

    int unsigned  n_checks = 0;
    int unsigned  n_err    = 0;
    fetch_entry_t m_fq[$];
    out_t         m_oq[$];
    logic [W-1:0] m_pc  = RESET_PC;
    bit           m_err = 1'b0;
    logic [W-1:0] mem_q[$];
    int unsigned  rv_mode   = 0;
    int unsigned  rv_pct    = 70;
    bit           rv_manual = 1'b0;
    bit           spur      = 1'b0;

    function automatic logic [W-1:0] instr_of(input logic [W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_req();
        return (reset === 1'b1) && (bus.redirect !== 1'b1) &&
               ((m_fq.size() + m_oq.size()) < DEPTH);
    endfunction

    function automatic void model_clear();
        m_fq.delete();
        m_oq.delete();
        m_pc  = RESET_PC;
        m_err = 1'b0;
    endfunction

    task automatic drive_mem();
        bit v = 1'b0;
        if (spur) v = 1'b1;
        else if (mem_q.size() > 0) begin
            case (rv_mode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(99) < rv_pct);
                default: v = rv_manual;
            endcase
        end
        bus.imem_rvalid = v;
        bus.imem_rdata  = (v && mem_q.size() > 0) ? instr_of(mem_q[0]) : W'($urandom);
    endtask

    task automatic compare();
        bit v = (m_fq.size() > 0);
        chk("imem_adr", bus.imem_adr, m_pc);
        chk("imem_req", W'(bus.imem_req), W'(exp_req()));
        chk("instr_valid", W'(bus.instr_valid), W'(v));
        chk("err", W'(err), W'(m_err));
        chk("pclow", W'(pclow), W'(m_pc[9:2]));
        if (v) begin
            chk("instrD", bus.instrD, m_fq[0].instr);
            chk("pc4D", bus.pc4D, m_fq[0].pc4);
        end else if (reset === 1'b0) begin
            chk("rst_instrD", bus.instrD, W'(INSTR_NOP));
            chk("rst_pc4D", bus.pc4D, '0);
        end
    endtask

    task automatic half_cycle();
        drive_mem();
        @(negedge clk);
        compare();
    endtask

    task automatic edge_cycle();
        logic         c_rst   = reset;
        logic         c_rv    = bus.imem_rvalid;
        logic         c_redir = bus.redirect;
        logic         c_ready = bus.imem_ready;
        logic         c_stall = bus.stallD;
        logic         c_dreq  = bus.imem_req;
        logic [W-1:0] c_rdata = bus.imem_rdata;
        logic [W-1:0] c_rpc   = bus.redirect_pc;
        logic [W-1:0] c_dadr  = bus.imem_adr;
        bit           c_ereq  = exp_req();
        bit           c_spur  = spur;
        bit           pop;
        bit           push    = 1'b0;
        fetch_entry_t e;
        out_t         o;
        @(posedge clk);
        if (c_rst === 1'b1) begin
            pop = (m_fq.size() > 0) && !c_stall && !c_redir;
            if (c_rv) begin
                if (m_oq.size() == 0) m_err = 1'b1;
                else begin
                    o = m_oq.pop_front();
                    if (!c_redir && !o.stale) begin
                        push    = 1'b1;
                        e.instr = c_rdata;
                        e.pc4   = o.pc4;
                    end
                end
            end
            if (pop)  void'(m_fq.pop_front());
            if (push) m_fq.push_back(e);
            if (c_redir) begin
                m_fq.delete();
                foreach (m_oq[i]) m_oq[i].stale = 1'b1;
                m_pc = c_rpc & ~W'(3);
            end else if (c_ereq && c_ready) begin
                m_oq.push_back('{pc4: m_pc + W'(4), stale: 1'b0});
                m_pc = m_pc + W'(4);
            end
        end
        if (c_rv && !c_spur && mem_q.size() > 0) void'(mem_q.pop_front());
        if (c_dreq && c_ready) mem_q.push_back(c_dadr);
        #1;
    endtask

    task automatic cycle();
        half_cycle();
        edge_cycle();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_adr"}, bus.imem_adr, RESET_PC);
        chk({tag, "_req"}, W'(bus.imem_req), '0);
        chk({tag, "_valid"}, W'(bus.instr_valid), '0);
        chk({tag, "_instrD"}, bus.instrD, '0);
        chk({tag, "_pc4D"}, bus.pc4D, '0);
        chk({tag, "_pclow"}, W'(pclow), '0);
        chk({tag, "_err"}, W'(err), '0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        mem_q.delete();
        bus.redirect   = 1'b0;
        bus.stallD     = 1'b0;
        bus.imem_ready = 1'b0;
        spur           = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    int unsigned exp_pop;

    initial begin
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.stallD      = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        #1 reset = 1'b0;
        model_clear();
        #1 chk_reset_vals("por");
        cycle();
        reset = 1'b1;

        // Streaming fetch, one-cycle memory latency, no stalls.
        bus.imem_ready = 1'b1;
        rv_mode = 0;
        for (int k = 0; k < 8; k++) begin
            half_cycle();
            chk("stream_adr", bus.imem_adr, W'(4 * k));
            chk("stream_pclow", W'(pclow), W'(k));
            if (k >= 2) begin
                chk("stream_valid", W'(bus.instr_valid), W'(1));
                chk("stream_pc4D", bus.pc4D, W'(4 * (k - 1)));
            end
            edge_cycle();
        end

        // Decode stall fills exactly DEPTH entries, then drains in order.
        do_reset();
        bus.imem_ready = 1'b1;
        bus.stallD = 1'b1;
        for (int k = 0; k < 10; k++) cycle();
        half_cycle();
        chk("stall_req", W'(bus.imem_req), '0);
        chk("stall_valid", W'(bus.instr_valid), W'(1));
        edge_cycle();
        bus.stallD = 1'b0;
        for (int j = 0; j < 4; j++) begin
            half_cycle();
            chk("drain_pc4D", bus.pc4D, W'(4 * (j + 1)));
            edge_cycle();
        end

        // Toggling imem_ready: popped pc4 values advance by exactly 4.
        do_reset();
        exp_pop = 4;
        for (int k = 0; k < 20; k++) begin
            bus.imem_ready = (k % 2 == 0);
            half_cycle();
            if (bus.instr_valid === 1'b1) begin
                chk("toggle_pc4D", bus.pc4D, W'(exp_pop));
                exp_pop += 4;
            end
            edge_cycle();
        end

        // Redirect with two requests in flight; both responses must be dropped.
        do_reset();
        rv_mode = 2;
        rv_manual = 1'b0;
        bus.imem_ready = 1'b1;
        cycle();
        cycle();
        bus.imem_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h100;
        half_cycle();
        chk("redir_req", W'(bus.imem_req), '0);
        edge_cycle();
        bus.redirect = 1'b0;
        rv_manual = 1'b1;
        half_cycle();
        chk("redir_empty", W'(bus.instr_valid), '0);
        chk("redir_adr", bus.imem_adr, 32'h100);
        edge_cycle();
        rv_manual = 1'b0;
        cycle();
        rv_manual = 1'b1;
        bus.imem_ready = 1'b1;
        half_cycle();
        chk("redir_req2", W'(bus.imem_req), W'(1));
        edge_cycle();
        bus.imem_ready = 1'b0;
        cycle();
        rv_manual = 1'b0;
        half_cycle();
        chk("redir_valid", W'(bus.instr_valid), W'(1));
        chk("redir_pc4D", bus.pc4D, 32'h104);
        chk("redir_instr", bus.instrD, instr_of(32'h100));
        edge_cycle();

        // Redirect coinciding with a response and a pop, unaligned target.
        do_reset();
        rv_mode = 0;
        bus.imem_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h203;
        half_cycle();
        chk("same_valid", W'(bus.instr_valid), W'(1));
        chk("same_rvalid", W'(bus.imem_rvalid), W'(1));
        chk("same_req", W'(bus.imem_req), '0);
        edge_cycle();
        bus.redirect = 1'b0;
        bus.imem_ready = 1'b0;
        half_cycle();
        chk("same_adr", bus.imem_adr, 32'h200);
        chk("same_empty", W'(bus.instr_valid), '0);
        chk("same_pclow", W'(pclow), 32'h80);
        edge_cycle();
        bus.imem_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();

        // Spurious rvalid sets a sticky error.
        do_reset();
        spur = 1'b1;
        cycle();
        spur = 1'b0;
        half_cycle();
        chk("spur_err", W'(err), W'(1));
        chk("spur_valid", W'(bus.instr_valid), '0);
        edge_cycle();
        for (int k = 0; k < 3; k++) cycle();
        half_cycle();
        chk("spur_sticky", W'(err), W'(1));
        edge_cycle();

        // Asynchronous reset mid-stream, then a stale response after release.
        bus.imem_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        #1 reset = 1'b0;
        model_clear();
        rv_mode = 2;
        rv_manual = 1'b0;
        bus.imem_ready = 1'b0;
        #1 chk_reset_vals("async");
        cycle();
        reset = 1'b1;
        rv_mode = 0;
        cycle();
        half_cycle();
        chk("stale_err", W'(err), W'(1));
        edge_cycle();

        // Randomized traffic.
        do_reset();
        rv_mode = 1;
        for (int k = 0; k < 3000; k++) begin
            bus.imem_ready  = ($urandom_range(3) != 0);
            bus.stallD      = ($urandom_range(2) == 0);
            bus.redirect    = ($urandom_range(19) == 0);
            bus.redirect_pc = W'($urandom);
            rv_pct          = $urandom_range(30, 95);
            if ($urandom_range(699) == 0) do_reset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
